// File: rtl/checkpoint_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : checkpoint_monitor                                               |
// | Purpose : Filters a pad-driven progress code and sequences the firmware     |
// |           start/fail/pass checkpoints into a pass/fail/timeout verdict.     |
// |           Define CHKMON_TIMEOUT_EN to build the progress watchdog.          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module checkpoint_monitor #(
    parameter int CODE_W      = 4,
    parameter int START_CODE  = 5,
    parameter int END_CODE    = 13,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 25000,
    parameter int TMO_W       = 16,
    parameter int CNT_W       = 4
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              clear,
    input  logic [CODE_W-1:0] code_in,
    output logic [2:0]        state,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  chk_count,
    output logic [CODE_W-1:0] last_code,
    output logic [CODE_W-1:0] fail_code,
    output logic              event_pulse
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    localparam int                 STB_W   = $clog2(STABLE_CYC + 1);
    localparam int                 EXP_W   = CODE_W + CNT_W + 2;
    localparam logic [STB_W-1:0]   C_STB   = STB_W'(STABLE_CYC);
    localparam logic [CODE_W-1:0]  C_START = CODE_W'(START_CODE);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYC < 1) begin : g_bad_stable
        $error("STABLE_CYC must be at least 1");
    end
    if ((END_CODE - START_CODE) < 2 || ((END_CODE - START_CODE) % 2) != 0) begin : g_bad_span
        $error("END_CODE-START_CODE must be even and at least 2");
    end
    if (END_CODE >= (1 << CODE_W)) begin : g_bad_end
        $error("END_CODE does not fit in CODE_W bits");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << TMO_W)) begin : g_bad_tmo
        $error("TIMEOUT_CYC must be in 1 .. 2**TMO_W-1");
    end
    if (((END_CODE - START_CODE) / 2) >= (1 << CNT_W)) begin : g_bad_cnt
        $error("CNT_W too narrow for the checkpoint count");
    end

    logic [CODE_W-1:0] r_sync [SYNC_STAGES];
    logic [STB_W-1:0]  r_stb;
    logic [STB_W-1:0]  w_stb;
    logic              w_load;
    logic [CODE_W-1:0] r_acc;
    logic              r_evt;

    state_t            r_state, w_state;
    logic [CNT_W-1:0]  r_chk, w_chk;
    logic [CODE_W-1:0] r_last, w_last;
    logic [CODE_W-1:0] r_fcode, w_fcode;
    logic              w_pulse;
    logic              r_pulse, r_running, r_done, r_pass, r_fail;
    logic [EXP_W-1:0]  w_exp_pass;

`ifdef CHKMON_TIMEOUT_EN
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] r_wdog;
    logic             r_timeout;
    logic             w_expire;
`endif

    // The edge that loads a new value into the last sync stage counts as the
    // first stable sample, so acc loads after STABLE_CYC identical edges.
    always_comb begin
        if (r_sync[SYNC_STAGES-2] != r_sync[SYNC_STAGES-1]) begin
            w_stb = STB_W'(1);
        end else if (r_stb != C_STB) begin
            w_stb = r_stb + STB_W'(1);
        end else begin
            w_stb = r_stb;
        end
    end

    assign w_load = (w_stb == C_STB);

    always_ff @(posedge clock) begin
        if (!resetb) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_stb <= '0;
            r_acc <= '0;
            r_evt <= 1'b0;
        end else begin
            r_sync[0] <= code_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_stb <= w_stb;
            if (w_load) begin
                r_acc <= r_sync[SYNC_STAGES-2];
            end
            r_evt <= w_load && (r_sync[SYNC_STAGES-2] != r_acc);
        end
    end

    assign w_exp_pass = EXP_W'(START_CODE + 2) + EXP_W'({r_chk, 1'b0});

    always_comb begin
        w_state = r_state;
        w_chk   = r_chk;
        w_last  = r_last;
        w_fcode = r_fcode;
        w_pulse = 1'b0;
        if (clear) begin
            w_state = S_IDLE;
            w_chk   = '0;
            w_last  = '0;
            w_fcode = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_evt) begin
                        w_pulse = 1'b1;
                        w_last  = r_acc;
                        if (r_acc == C_START) begin
                            w_state = S_RUN;
                            w_chk   = '0;
                        end
                    end
                end
                S_RUN: begin
                    if (r_evt) begin
                        w_pulse = 1'b1;
                        w_last  = r_acc;
                        if (EXP_W'(r_acc) == w_exp_pass) begin
                            w_chk = r_chk + CNT_W'(1);
                            if (w_exp_pass == EXP_W'(END_CODE)) begin
                                w_state = S_PASS;
                            end
                        end else begin
                            w_state = S_FAIL;
                            w_fcode = r_acc;
                        end
                    end
`ifdef CHKMON_TIMEOUT_EN
                    else if (w_expire) begin
                        w_state = S_TIMEOUT;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_state   <= S_IDLE;
            r_chk     <= '0;
            r_last    <= '0;
            r_fcode   <= '0;
            r_pulse   <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_chk     <= w_chk;
            r_last    <= w_last;
            r_fcode   <= w_fcode;
            r_pulse   <= w_pulse;
            r_running <= (w_state == S_RUN);
            r_done    <= (w_state == S_PASS) || (w_state == S_FAIL) || (w_state == S_TIMEOUT);
            r_pass    <= (w_state == S_PASS);
            r_fail    <= (w_state == S_FAIL);
        end
    end

`ifdef CHKMON_TIMEOUT_EN
    // Any event in RUN either passes a checkpoint or leaves RUN, so it clears.
    always_ff @(posedge clock) begin
        if (!resetb || clear || r_state != S_RUN || r_evt) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + TMO_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= (w_state == S_TIMEOUT);
        end
    end

    assign w_expire = (r_wdog == C_TMO_LAST);
    assign timeout  = r_timeout;
`else
    assign timeout  = 1'b0;
`endif

    assign state       = r_state;
    assign running     = r_running;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign chk_count   = r_chk;
    assign last_code   = r_last;
    assign fail_code   = r_fcode;
    assign event_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_checkpoint_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_checkpoint_monitor                                            |
// | Purpose : Scoreboard bench for checkpoint_monitor with directed code runs.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_checkpoint_monitor;

    logic       clock = 1'b0;
    logic       resetb;
    logic       clear;
    logic [3:0] code_in;
    logic [2:0] state;
    logic       running, done, pass, fail, timeout;
    logic [3:0] chk_count, last_code, fail_code;
    logic       event_pulse;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    typedef struct {
        int due;
        int st;
        int chk;
        int last;
        int fc;
    } exp_t;

    exp_t q[$];

    checkpoint_monitor #(
        .CODE_W      (4),
        .START_CODE  (5),
        .END_CODE    (13),
        .SYNC_STAGES (2),
        .STABLE_CYC  (4),
        .TIMEOUT_CYC (100),
        .TMO_W       (16),
        .CNT_W       (4)
    ) dut (
        .clock       (clock),
        .resetb      (resetb),
        .clear       (clear),
        .code_in     (code_in),
        .state       (state),
        .running     (running),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .chk_count   (chk_count),
        .last_code   (last_code),
        .fail_code   (fail_code),
        .event_pulse (event_pulse)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int outs();
        return int'({state, running, done, pass, fail, timeout,
                     chk_count, last_code, fail_code, event_pulse});
    endfunction

    // Scoreboard monitor: every event_pulse must match the oldest expectation.
    always @(negedge clock) begin : mon
        exp_t e;
        if (event_pulse) begin
            n_pulses++;
            if (q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                e = q.pop_front();
                check("pulse_cycle", cyc, e.due);
                check("pulse_state", int'(state), e.st);
                check("pulse_chk", int'(chk_count), e.chk);
                check("pulse_last", int'(last_code), e.last);
                check("pulse_fcode", int'(fail_code), e.fc);
                check("pulse_flags", int'({running, done, pass, fail, timeout}),
                      int'({e.st == 1, e.st >= 2, e.st == 2, e.st == 3, e.st == 4}));
            end
        end
    end

    task automatic drive(input int v, input bit pulse, input int st, input int chk,
                         input int fc, input int hold);
        exp_t e;
        code_in = 4'(v);
        if (pulse) begin
            e.due  = cyc + 6;
            e.st   = st;
            e.chk  = chk;
            e.last = v;
            e.fc   = fc;
            q.push_back(e);
        end
        repeat (hold) @(negedge clock);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clear_outputs", outs(), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int p0;
        int t;
        resetb  = 1'b0;
        clear   = 1'b0;
        code_in = 4'd0;
        repeat (3) @(negedge clock);
        check("reset_outputs", outs(), 0);
        resetb = 1'b1;

        // Full passing sequence
        p0 = n_pulses;
        drive(5,  1, 1, 0, 0, 20);
        drive(7,  1, 1, 1, 0, 20);
        drive(9,  1, 1, 2, 0, 20);
        drive(11, 1, 1, 3, 0, 20);
        drive(13, 1, 2, 4, 0, 20);
        check("pass_state", int'(state), 2);
        check("pass_flag", int'(pass), 1);
        check("pass_chk", int'(chk_count), 4);
        check("pass_last", int'(last_code), 13);
        check("pass_pulses", n_pulses - p0, 5);
        check("pass_drained", q.size(), 0);
        do_clear();

        // Explicit fail code, then terminal state ignores further codes
        drive(5, 1, 1, 0, 0, 20);
        drive(7, 1, 1, 1, 0, 20);
        drive(8, 1, 3, 1, 8, 20);
        drive(9, 0, 0, 0, 0, 20);
        check("fail_state", int'(state), 3);
        check("fail_code", int'(fail_code), 8);
        check("fail_last_frozen", int'(last_code), 8);
        check("fail_chk", int'(chk_count), 1);
        check("fail_drained", q.size(), 0);
        do_clear();

        // Skipped pair, then a non-start code in IDLE
        drive(5, 1, 1, 0, 0, 20);
        drive(9, 1, 3, 0, 9, 20);
        check("skip_fail_code", int'(fail_code), 9);
        do_clear();
        drive(3, 1, 0, 0, 0, 20);
        check("idle_state", int'(state), 0);
        check("idle_last", int'(last_code), 3);
        check("idle_drained", q.size(), 0);

        // Glitches shorter than the stability window
        p0 = n_pulses;
        drive(5, 1, 1, 0, 0, 10);
        drive(6, 0, 0, 0, 0, 3);
        drive(5, 0, 0, 0, 0, 10);
        drive(7, 0, 0, 0, 0, 2);
        drive(5, 0, 0, 0, 0, 10);
        check("glitch_pulses", n_pulses - p0, 1);
        check("glitch_state", int'(state), 1);
        check("glitch_last", int'(last_code), 5);
        check("glitch_drained", q.size(), 0);
        do_clear();

        // Reset mid-RUN with the start code held across it
        drive(0, 1, 0, 0, 0, 10);
        drive(5, 1, 1, 0, 0, 15);
        drive(7, 1, 1, 1, 0, 15);
        drive(9, 1, 1, 2, 0, 15);
        check("prereset_chk", int'(chk_count), 2);
        code_in = 4'd5;
        resetb  = 1'b0;
        @(negedge clock);
        check("reset_mid_run", outs(), 0);
        resetb = 1'b1;
        t = cyc + 6;
        drive(5, 1, 1, 0, 0, 0);

`ifdef CHKMON_TIMEOUT_EN
        while (cyc < t + 99) @(negedge clock);
        check("tmo_not_yet_state", int'(state), 1);
        check("tmo_not_yet_flag", int'(timeout), 0);
        @(negedge clock);
        check("tmo_state", int'(state), 4);
        check("tmo_flags", int'({timeout, done, pass, fail, running}), 5'b11000);
        do_clear();

        // An event on the expiry edge wins over the watchdog
        drive(0, 1, 0, 0, 0, 10);
        t = cyc + 6;
        drive(5, 1, 1, 0, 0, 0);
        while (cyc < t + 94) @(negedge clock);
        drive(7, 1, 1, 1, 0, 7);
        check("race_state", int'(state), 1);
        check("race_timeout", int'(timeout), 0);
        check("race_chk", int'(chk_count), 1);
`else
        repeat (10000) @(negedge clock);
        check("notmo_state", int'(state), 1);
        check("notmo_flag", int'(timeout), 0);
`endif
        check("final_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/checkpoint_monitor.md
# checkpoint_monitor

Synthesizable checkpoint sequencer for SoC-level firmware self-tests. It samples a firmware-driven progress code from a group of `mprj_io` pads and enforces the start/fail/pass code sequence used by the user-project-control tests (start, then alternating fail/pass code pairs up to a final pass code). It reports pass, fail and timeout status in hardware, so bring-up silicon and FPGA builds can report the verdict without a simulator monitor. Code width, code range, input filtering and the progress watchdog are all parameters.

## Interface
- `CODE_W`, 4: width of the progress code.
- `START_CODE`, 5: code that arms the monitor.
- `END_CODE`, 13: final pass code. Constraints: `END_CODE-START_CODE` is even and ≥2, and `END_CODE < 2**CODE_W`.
- `SYNC_STAGES`, 2: synchronizer depth for `code_in` (≥2).
- `STABLE_CYC`, 4: number of consecutive identical synchronized samples required before a code is accepted (≥1).
- `TIMEOUT_CYC`, 25000: maximum number of RUN cycles allowed without progress.
- `TMO_W`, 16: watchdog counter width (`TIMEOUT_CYC < 2**TMO_W`).
- `CNT_W`, 4: checkpoint counter width (≥ bits needed for `(END_CODE-START_CODE)/2`).

Ports:
- `clock`  in  1  single clock; every flop is clocked on its rising edge.
- `resetb`  in  1  synchronous, active-low reset.
- `clear`  in  1  synchronous return to IDLE. Priority order: `resetb`, then `clear`, then code events.
- `code_in`  in  `CODE_W`  asynchronous progress code from the pads.
- `state`  out  3  encodings: IDLE=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4.
- `running`  out  1  high while `state`==RUN.
- `done`  out  1  high in PASS, FAIL or TIMEOUT.
- `pass`, `fail`, `timeout`  out  1 each  terminal verdict flags, mutually exclusive.
- `chk_count`  out  `CNT_W`  number of checkpoints passed.
- `last_code`  out  `CODE_W`  most recently accepted code.
- `fail_code`  out  `CODE_W`  code that caused FAIL; 0 otherwise.
- `event_pulse`  out  1  one-cycle pulse for each accepted code acted on in IDLE or RUN.

## Operation
- Input path: `code_in` → `SYNC_STAGES` flop chain → stability filter → accepted code register `acc`.
  - The stability counter resets whenever the synchronized value changes.
  - `acc` loads once the synchronized value has been identical for `STABLE_CYC` consecutive edges.
  - Only a change of `acc` is an event. Holding a value never re-triggers.
- Expected codes at checkpoint k (k = `chk_count`): fail code `START_CODE+1+2k`, pass code `START_CODE+2+2k`.
- IDLE:
  - Event == `START_CODE` → RUN; `chk_count`=0; watchdog cleared.
  - Any other event: `last_code` updates, nothing else changes, no error.
- RUN:
  - Event == expected pass code, not `END_CODE` → `chk_count`+1, watchdog cleared, stay in RUN.
  - Event == `END_CODE` as expected pass code → PASS, `chk_count`+1.
  - Event == expected fail code → FAIL, `fail_code`=code.
  - Any other event (out of order, repeated start, skipped pair) → FAIL, `fail_code`=code.
- PASS/FAIL/TIMEOUT are terminal.
  - Events are ignored: `last_code`, `event_pulse` and all flags stay frozen.
  - Exit only through `clear` or `resetb`.
- `clear` sets state, flags, `chk_count`, `fail_code`, `last_code` and the watchdog to their reset values. It does not touch the synchronizer, filter or `acc`, so a held code does not re-trigger after `clear`.

## Timing
- Reset values: every flop 0, including the sync chain, filter counter and `acc`; `state`=IDLE. All outputs 0.
- Latency from a `code_in` change (setup met before edge 0):
  - Synchronized value valid at edge `SYNC_STAGES`.
  - `acc` updates at edge `SYNC_STAGES+STABLE_CYC-1`.
  - `state`, flags, counters and `event_pulse` update on the next edge: `SYNC_STAGES+STABLE_CYC` edges in total (6 with defaults).
- A glitch shorter than `STABLE_CYC` synchronized cycles is never accepted.
- Watchdog:
  - Increments each cycle in RUN.
  - Cleared on RUN entry and on each passed checkpoint.
  - The edge on which it equals `TIMEOUT_CYC-1` moves the block to TIMEOUT.
- An event and a watchdog expiry on the same edge: the event wins.
- `resetb` low during RUN: all state returns to reset values on that edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `CHKMON_TIMEOUT_EN` defined: watchdog counter and TIMEOUT state are present, as described above.
- `CHKMON_TIMEOUT_EN` undefined: no watchdog flops; `timeout` is tied to 0; TIMEOUT is unreachable; RUN waits indefinitely.

## Test plan
- Defaults; drive 5, 7, 9, 11, 13, each held 20 cycles → `state` goes 1 then 2; `pass`=1; `chk_count`=4; `last_code`=13; five `event_pulse` pulses; each response 6 edges after the pin change.
- Drive 5, 7, then 8 → FAIL; `fail_code`=8; `chk_count`=1. Then drive 9 → no change. Pulse `clear` → IDLE with all outputs 0.
- Drive 5, 9 (skips 7) → FAIL with `fail_code`=9. Drive 3 in IDLE → `last_code`=3, state stays 0.
- Drive 5 → 6 for 3 cycles → 5: the 6 is never accepted and no `event_pulse` fires. Then a 2-cycle glitch to 7 is also rejected.
- With `CHKMON_TIMEOUT_EN`, `TIMEOUT_CYC`=100: drive 5, hold → `timeout`=1 exactly 100 cycles after entering RUN. Drive 5 then 7 at RUN cycle 99 → 7 is accepted and no timeout. Without the macro: drive 5, wait 10000 cycles → `state` still 1.
- Assert `resetb` low for one edge mid-RUN (`chk_count`=2) → all outputs 0 on that edge. Hold `code_in`=5 across reset → monitor re-arms to RUN 6 edges after release.
